// File: rtl/trap_controller.sv
// Trap entry/exit sequencer: arbitrates an illegal-instruction exception against
// four round-robin interrupts and pulses the CSR/PC controls for entry and mret.
module trap_controller #(
    parameter int IRQ_BASE = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  irq_i,
    input  logic [31:0] mie_i,
    input  logic        exc_i,
    input  logic        mret_i,
    input  logic        instr_valid_i,
    output logic [2:0]  csr_op_o,
    output logic [31:0] mcause_o,
    output logic        trap_o,
    output logic        mret_o,
    output logic [3:0]  irq_ack_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {IDLE, ENTRY, HANDLER, EXIT} state_e;

    localparam logic [31:0] EXC_CAUSE = 32'd2;
    localparam logic [2:0]  OP_TRAP   = 3'b100;

    state_e      state_q, state_d;
    logic [1:0]  rr_ptr_q, rr_ptr_d;
    logic [31:0] mcause_q, mcause_d;
    logic [3:0]  ack_q, ack_d;

    logic [3:0]  pending;
    logic        grant_vld;
    logic [1:0]  grant_idx;

    // Only the four enable bits for our sources matter; the rest of mie is ignored.
    logic [31:0] mie_unused_bits;
    logic        unused_mie;
    assign mie_unused_bits = mie_i & ~(32'hF << IRQ_BASE);
    assign unused_mie      = ^mie_unused_bits;

    // Scan downward so the source closest at-or-after rr_ptr is written last and wins.
    always_comb begin
        pending   = irq_i & mie_i[IRQ_BASE +: 4];
        grant_vld = 1'b0;
        grant_idx = rr_ptr_q;
        for (int i = 3; i >= 0; i--) begin
            if (pending[rr_ptr_q + 2'(i)]) begin
                grant_vld = 1'b1;
                grant_idx = rr_ptr_q + 2'(i);
            end
        end
    end

    // NOTE: every *_d gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        mcause_d = mcause_q;
        ack_d    = ack_q;
        case (state_q)
            IDLE: begin
                if (instr_valid_i && exc_i) begin
                    state_d  = ENTRY;
                    mcause_d = EXC_CAUSE;
                    ack_d    = 4'b0000;
                end else if (instr_valid_i && grant_vld) begin
                    state_d  = ENTRY;
                    mcause_d = {1'b1, 26'b0, 5'(IRQ_BASE) + {3'b000, grant_idx}};
                    ack_d    = 4'b0001 << grant_idx;
                    rr_ptr_d = grant_idx + 2'd1;
                end
            end
            ENTRY: state_d = HANDLER;
            HANDLER: begin
                if (instr_valid_i && exc_i) begin
                    state_d  = ENTRY;
                    mcause_d = EXC_CAUSE;
                    ack_d    = 4'b0000;
                end else if (mret_i) begin
                    state_d = EXIT;
                end
            end
            EXIT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; reset is asynchronous and active-low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= 2'd0;
            mcause_q <= 32'd0;
            ack_q    <= 4'b0000;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            mcause_q <= mcause_d;
            ack_q    <= ack_d;
        end
    end

    assign csr_op_o  = (state_q == ENTRY) ? OP_TRAP : 3'b000;
    assign trap_o    = (state_q == ENTRY);
    assign irq_ack_o = (state_q == ENTRY) ? ack_q : 4'b0000;
    assign mret_o    = (state_q == EXIT);
    assign busy_o    = (state_q != IDLE);
    assign mcause_o  = mcause_q;

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: a behavioural model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_trap_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  irq_i = '0;
    logic [31:0] mie_i = '0;
    logic        exc_i = 1'b0;
    logic        mret_i = 1'b0;
    logic        instr_valid_i = 1'b0;
    logic [2:0]  csr_op_o;
    logic [31:0] mcause_o;
    logic        trap_o;
    logic        mret_o;
    logic [3:0]  irq_ack_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    trap_controller #(.IRQ_BASE(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .irq_i         (irq_i),
        .mie_i         (mie_i),
        .exc_i         (exc_i),
        .mret_i        (mret_i),
        .instr_valid_i (instr_valid_i),
        .csr_op_o      (csr_op_o),
        .mcause_o      (mcause_o),
        .trap_o        (trap_o),
        .mret_o        (mret_o),
        .irq_ack_o     (irq_ack_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 trap entry, 2 in handler, 3 returning.
    int          m_phase;
    int          m_ptr;
    logic [31:0] m_cause;
    logic [3:0]  m_ack;

    function automatic int pick(input logic [3:0] irq, input logic [31:0] mie, input int ptr);
        for (int i = 0; i < 4; i++) begin
            int k;
            k = (ptr + i) % 4;
            if (irq[k] && mie[16 + k]) return k;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_ptr   <= 0;
            m_cause <= 32'd0;
            m_ack   <= 4'd0;
        end else if (m_phase == 0) begin
            if (instr_valid_i && exc_i) begin
                m_phase <= 1;
                m_cause <= 32'd2;
                m_ack   <= 4'd0;
            end else if (instr_valid_i && pick(irq_i, mie_i, m_ptr) >= 0) begin
                m_phase <= 1;
                m_cause <= 32'h8000_0000 + 32'(16 + pick(irq_i, mie_i, m_ptr));
                m_ack   <= 4'(1 << pick(irq_i, mie_i, m_ptr));
                m_ptr   <= (pick(irq_i, mie_i, m_ptr) + 1) % 4;
            end
        end else if (m_phase == 1) begin
            m_phase <= 2;
        end else if (m_phase == 2) begin
            if (instr_valid_i && exc_i) begin
                m_phase <= 1;
                m_cause <= 32'd2;
                m_ack   <= 4'd0;
            end else if (mret_i) begin
                m_phase <= 3;
            end
        end else begin
            m_phase <= 0;
        end
    end

    always @(negedge clk) begin
        check("csr_op", 32'(csr_op_o), (m_phase == 1) ? 32'd4 : 32'd0);
        check("trap", 32'(trap_o), 32'(m_phase == 1));
        check("irq_ack", 32'(irq_ack_o), (m_phase == 1) ? 32'(m_ack) : 32'd0);
        check("mret", 32'(mret_o), 32'(m_phase == 3));
        check("busy", 32'(busy_o), 32'(m_phase != 0));
        check("mcause", mcause_o, m_cause);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        tick();
        tick();
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_mcause", mcause_o, 32'd0);
        check("rst_csr_op", 32'(csr_op_o), 32'd0);
        rst_n = 1'b1;

        // Single interrupt from source 0.
        mie_i = 32'h0001_0000; irq_i = 4'b0001; instr_valid_i = 1'b1;
        tick();
        check("a_csr_op", 32'(csr_op_o), 32'd4);
        check("a_trap", 32'(trap_o), 32'd1);
        check("a_ack", 32'(irq_ack_o), 32'h1);
        check("a_mcause", mcause_o, 32'h8000_0010);
        irq_i = 4'b0000;
        tick();
        check("a_handler_trap", 32'(trap_o), 32'd0);
        mret_i = 1'b1;
        tick();
        check("a_mret", 32'(mret_o), 32'd1);
        mret_i = 1'b0;
        tick();
        check("a_idle_busy", 32'(busy_o), 32'd0);

        // mret outside handler is ignored.
        mret_i = 1'b1;
        tick();
        check("idle_mret", 32'(mret_o), 32'd0);
        mret_i = 1'b0;

        // Exception beats all interrupts and leaves the pointer alone.
        mie_i = 32'h000F_0000; irq_i = 4'b1111; exc_i = 1'b1;
        tick();
        check("e_mcause", mcause_o, 32'd2);
        check("e_ack", 32'(irq_ack_o), 32'd0);
        check("e_trap", 32'(trap_o), 32'd1);
        exc_i = 1'b0; irq_i = 4'b0000;
        tick();
        // Nested exception wins over simultaneous mret.
        exc_i = 1'b1; mret_i = 1'b1;
        tick();
        check("n_mcause", mcause_o, 32'd2);
        check("n_trap", 32'(trap_o), 32'd1);
        exc_i = 1'b0; mret_i = 1'b0;
        // Request raised and dropped while in the handler is never acknowledged.
        irq_i = 4'b0100;
        tick();
        irq_i = 4'b0000; mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
        tick();
        tick();
        check("drop_busy", 32'(busy_o), 32'd0);

        // Four back-to-back sequences from a fresh pointer.
        reset_pulse();
        irq_i = 4'b1111;
        for (int n = 0; n < 4; n++) begin
            tick();
            check("rr_ack", 32'(irq_ack_o), 32'(1 << n));
            tick();
            mret_i = 1'b1;
            tick();
            mret_i = 1'b0;
            tick();
        end
        irq_i = 4'b0000;
        tick();

        // Disabled source stays quiet until enabled.
        mie_i = 32'h0000_0000; irq_i = 4'b0100;
        tick();
        tick();
        check("mask_busy", 32'(busy_o), 32'd0);
        check("mask_trap", 32'(trap_o), 32'd0);
        mie_i = 32'h0004_0000;
        tick();
        check("en_trap", 32'(trap_o), 32'd1);
        check("en_mcause", mcause_o, 32'h8000_0012);
        irq_i = 4'b0000;
        tick();

        // Asynchronous reset in the handler, then first grant uses pointer 0.
        #1;
        rst_n = 1'b0;
        #1;
        check("async_busy", 32'(busy_o), 32'd0);
        check("async_mcause", mcause_o, 32'd0);
        tick();
        rst_n = 1'b1;
        mie_i = 32'h000F_0000; irq_i = 4'b1010;
        tick();
        check("post_rst_ack", 32'(irq_ack_o), 32'h2);
        irq_i = 4'b0000;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
